congestion_monitor: RTL and testbench
=====================================

CONGESTION_MONITOR -- requirements
Module: congestion_monitor

Interface
REQ-001 SHALL have parameter V, default 4: virtual channels per output port.
REQ-002 SHALL have parameter B, default 4: buffer depth (flits) per VC.
REQ-003 SHALL have parameter CONGw, default 2: congestion level width, matching the per-router congestion field consumed by the port-preselection agent.
REQ-004 SHALL have parameter WINDOW, default 16: sampling window length in cycles, power of 2, minimum 2.
REQ-005 SHALL have parameter DEBUG_EN, default 1: enables the error flag.
REQ-006 SHALL have port clk, input, 1: the single clock.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port en, input, 1: window advance enable.
REQ-009 SHALL have port flit_out_wr, input, 4: one bit per neighbour output port (0=east, 1=north, 2=west, 3=south), flit sent downstream.
REQ-010 SHALL have port credit_in, input, 4: one bit per neighbour port, credit returned from downstream.
REQ-011 SHALL have port congestion_out, output, CONGw: registered router congestion level.
REQ-012 SHALL have port congestion_valid, output, 1: one-cycle pulse when congestion_out updates.
REQ-013 SHALL have port err_flag, output, 1: sticky credit-accounting error.

Function
REQ-014 SHALL keep per-port occupancy counter occ[p], width clog2(V*B+1), range 0..MAXP, where MAXP = V*B.
REQ-015 SHALL increment occ[p] on flit_out_wr[p] alone, decrement on credit_in[p] alone, and hold it when both or neither are asserted.
REQ-016 SHALL saturate occ[p] at MAXP on increment-at-max and at 0 on decrement-at-zero, setting err_flag in either case when DEBUG_EN=1.
REQ-017 SHALL hold err_flag at 0 when DEBUG_EN=0.
REQ-018 SHALL update occupancy counters regardless of en.
REQ-019 SHALL compute sum = occ[0]+occ[1]+occ[2]+occ[3] from registered values each cycle, with width wide enough for 4*MAXP.
REQ-020 SHALL keep window counter wcnt (0..WINDOW-1) and accumulator acc (no overflow for WINDOW*4*MAXP).
REQ-021 SHALL, while en=1 and wcnt<WINDOW-1, add sum to acc and increment wcnt.
REQ-022 SHALL, when en=1 and wcnt=WINDOW-1, compute avg = (acc+sum)>>log2(WINDOW) and level = (avg*2^CONGw)/(4*MAXP), saturated to 2^CONGw-1.
REQ-023 SHALL, in that same cycle, register level into congestion_out, assert congestion_valid for the following cycle only, and clear acc and wcnt to 0.
REQ-024 SHALL give latency from the last window sample to a visible congestion_out of one clock.
REQ-025 SHALL, while en=0, freeze wcnt and acc, keep congestion_valid low and keep congestion_out held.
REQ-026 SHALL make divisions power-of-2 shifts when 4*MAXP is a power of 2, and a constant comparator ladder otherwise.

Reset
REQ-027 SHALL, on reset assertion at any time including mid-window, asynchronously clear all occ, wcnt, acc, congestion_out, congestion_valid and err_flag to 0.
REQ-028 SHALL start a new window at wcnt=0 on the first rising edge after reset deassertion.

Verification (V=4, B=4, WINDOW=16, CONGw=2; MAXP=16, full scale 64)
REQ-029 SHALL cover: reset release, en=1, no traffic -> congestion_valid pulses on cycle 16 and every 16 cycles after, congestion_out=0, err_flag=0.
REQ-030 SHALL cover: 16 flit_out_wr[0] pulses before a window start, then idle -> sum=16, avg=16, congestion_out=1.
REQ-031 SHALL cover: all four ports filled to 16 -> avg=64, level 4 saturates, congestion_out=3; one more flit_out_wr[2] -> occ[2] stays 16, err_flag=1 and stays 1 until reset.
REQ-032 SHALL cover: flit_out_wr[1] and credit_in[1] together at occ[1]=5 -> occ[1] stays 5; credit_in[3] at occ[3]=0 -> occ[3]=0, err_flag=1.
REQ-033 SHALL cover: en=0 for 10 cycles mid-window at wcnt=7 -> no valid pulse, wcnt resumes at 7, window end delayed by 10 cycles.
REQ-034 SHALL cover: reset asserted at wcnt=9 with congestion_out=2 -> outputs 0 immediately, without waiting for a clock edge; the next valid pulse comes 16 cycles after reset release.

Source files
------------

// File: rtl/congestion_monitor.sv
// Router congestion monitor: tracks per-port downstream buffer occupancy from
// flit/credit events, averages total occupancy over a fixed sampling window
// and publishes a quantised congestion level with a one-cycle valid pulse.
module congestion_monitor #(
  parameter int V        = 4,
  parameter int B        = 4,
  parameter int CONGw    = 2,
  parameter int WINDOW   = 16,
  parameter int DEBUG_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [3:0]       flit_out_wr,
  input  logic [3:0]       credit_in,
  output logic [CONGw-1:0] congestion_out,
  output logic             congestion_valid,
  output logic             err_flag
);

  localparam int MAXP      = V * B;
  localparam int OW        = $clog2(MAXP + 1);
  localparam int FULL      = 4 * MAXP;
  localparam int SW        = $clog2(FULL + 1);
  localparam int AW        = $clog2(WINDOW * FULL + 1);
  localparam int WW        = $clog2(WINDOW);
  localparam int LW        = SW + CONGw;
  localparam int LMAX      = (1 << CONGw) - 1;
  localparam bit FULL_POW2 = (FULL & (FULL - 1)) == 0;
  localparam int FSH       = $clog2(FULL);

  logic [OW-1:0]    occ [4];
  logic [3:0]       inc, dec, ovf, unf;
  logic [SW-1:0]    sum;
  logic [AW-1:0]    acc;
  logic [AW-1:0]    win_total;
  logic [SW-1:0]    avg;
  logic [LW-1:0]    scaled;
  logic [CONGw-1:0] level;
  logic [WW-1:0]    wcnt;
  logic             last;

  // Classify each port's event and flag saturation at either end
  always_comb begin
    inc = '0;
    dec = '0;
    ovf = '0;
    unf = '0;
    for (int unsigned p = 0; p < 4; p++) begin
      inc[p] = flit_out_wr[p] & ~credit_in[p];
      dec[p] = credit_in[p] & ~flit_out_wr[p];
      ovf[p] = inc[p] && (occ[p] == OW'(MAXP));
      unf[p] = dec[p] && (occ[p] == '0);
    end
  end

  // Per-port occupancy counters, saturating, independent of en
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned p = 0; p < 4; p++) occ[p] <= '0;
    end else begin
      for (int unsigned p = 0; p < 4; p++) begin
        if (inc[p] && !ovf[p])      occ[p] <= occ[p] + OW'(1);
        else if (dec[p] && !unf[p]) occ[p] <= occ[p] - OW'(1);
      end
    end
  end

  generate
    if (DEBUG_EN != 0) begin : g_err
      // Sticky credit-accounting error
      always_ff @(posedge clk or posedge reset) begin
        if (reset)            err_flag <= 1'b0;
        else if (|(ovf | unf)) err_flag <= 1'b1;
      end
    end else begin : g_no_err
      // Error reporting disabled
      always_comb err_flag = 1'b0;
    end
  endgenerate

  // Window arithmetic from registered occupancies
  always_comb begin
    sum       = SW'(occ[0]) + SW'(occ[1]) + SW'(occ[2]) + SW'(occ[3]);
    win_total = acc + AW'(sum);
    avg       = SW'(win_total >> WW);
    scaled    = {avg, {CONGw{1'b0}}};
    last      = (wcnt == WW'(WINDOW - 1));
  end

  generate
    if (FULL_POW2) begin : g_shift
      logic [LW-1:0] quot;
      // Full scale is a power of two: division is a shift, then saturate
      always_comb begin
        quot  = scaled >> FSH;
        level = (quot > LW'(LMAX)) ? CONGw'(LMAX) : quot[CONGw-1:0];
      end
    end else begin : g_ladder
      // Floor division by full scale as a constant threshold ladder
      always_comb begin
        level = '0;
        for (int unsigned k = 1; k <= LMAX; k++) begin
          if (scaled >= LW'(k * FULL)) level = CONGw'(k);
        end
      end
    end
  endgenerate

  // Sampling window: accumulate, then publish level on the last sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt             <= '0;
      acc              <= '0;
      congestion_out   <= '0;
      congestion_valid <= 1'b0;
    end else if (en) begin
      if (last) begin
        wcnt             <= '0;
        acc              <= '0;
        congestion_out   <= level;
        congestion_valid <= 1'b1;
      end else begin
        wcnt             <= wcnt + WW'(1);
        acc              <= win_total;
        congestion_valid <= 1'b0;
      end
    end else begin
      congestion_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_congestion_monitor.sv
// Scoreboard bench for congestion_monitor: a transaction-level model pushes
// expected congestion levels; a monitor pops them when the DUT pulses valid.
module tb_congestion_monitor;

  localparam int WINDOW = 16;
  localparam int MAXP   = 16;
  localparam int FULL   = 64;
  localparam int LEVELS = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [3:0] flit_out_wr;
  logic [3:0] credit_in;
  logic [1:0] congestion_out;
  logic       congestion_valid;
  logic       err_flag;

  congestion_monitor #(
    .V(4), .B(4), .CONGw(2), .WINDOW(WINDOW), .DEBUG_EN(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .flit_out_wr(flit_out_wr),
    .credit_in(credit_in),
    .congestion_out(congestion_out),
    .congestion_valid(congestion_valid),
    .err_flag(err_flag)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: occupancy bookkeeping and window averaging
  int m_occ [4];
  bit m_err;
  int m_wsum, m_wn, m_lvl;
  int exp_q [$];

  always @(posedge clk or posedge reset) begin
    int s, avg, l;
    if (reset) begin
      for (int p = 0; p < 4; p++) m_occ[p] = 0;
      m_err = 0; m_wsum = 0; m_wn = 0; m_lvl = 0;
      exp_q.delete();
    end else begin
      s = m_occ[0] + m_occ[1] + m_occ[2] + m_occ[3];
      for (int p = 0; p < 4; p++) begin
        if (flit_out_wr[p] && !credit_in[p]) begin
          if (m_occ[p] == MAXP) m_err = 1; else m_occ[p]++;
        end else if (credit_in[p] && !flit_out_wr[p]) begin
          if (m_occ[p] == 0) m_err = 1; else m_occ[p]--;
        end
      end
      if (en) begin
        m_wsum += s;
        m_wn++;
        if (m_wn == WINDOW) begin
          avg = m_wsum / WINDOW;
          l = avg * LEVELS / FULL;
          if (l > LEVELS - 1) l = LEVELS - 1;
          exp_q.push_back(l);
          m_lvl = l;
          m_wsum = 0;
          m_wn = 0;
        end
      end
    end
  end

  // Monitor: compare outputs on the falling edge
  always @(negedge clk) begin
    int want, e;
    if (!reset) begin
      want = (exp_q.size() != 0) ? 1 : 0;
      check("valid_pulse", congestion_valid, want);
      if (want == 1) begin
        e = exp_q.pop_front();
        if (congestion_valid) check("level", congestion_out, e);
      end
      check("held_out", congestion_out, m_lvl);
      check("err_flag", err_flag, m_err);
    end
  end

  task automatic cyc(input logic [3:0] f, input logic [3:0] c, input logic e);
    @(negedge clk);
    flit_out_wr = f;
    credit_in   = c;
    en          = e;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1; flit_out_wr = '0; credit_in = '0; en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] f, c;
    reset = 1'b1; en = 1'b0; flit_out_wr = '0; credit_in = '0;
    repeat (2) @(negedge clk);
    check("rst_out", congestion_out, 0);
    check("rst_valid", congestion_valid, 0);
    check("rst_err", err_flag, 0);
    reset = 1'b0;

    // Idle traffic: level 0 every window
    repeat (48) cyc(4'b0000, 4'b0000, 1'b1);

    // Port 0 filled to 16 -> average 16 -> level 1
    repeat (16) cyc(4'b0001, 4'b0000, 1'b0);
    repeat (16) cyc(4'b0000, 4'b0000, 1'b1);

    // All ports full -> level saturates at 3; overflow on port 2
    repeat (16) cyc(4'b1110, 4'b0000, 1'b0);
    repeat (16) cyc(4'b0000, 4'b0000, 1'b1);
    cyc(4'b0100, 4'b0000, 1'b0);
    repeat (4) cyc(4'b0000, 4'b0000, 1'b1);

    // Simultaneous flit+credit holds; credit at empty sets error
    pulse_reset();
    repeat (5) cyc(4'b0010, 4'b0000, 1'b0);
    cyc(4'b0010, 4'b0010, 1'b0);
    cyc(4'b0000, 4'b1000, 1'b0);
    repeat (16) cyc(4'b0000, 4'b0000, 1'b1);

    // en low for 10 cycles at wcnt=7 delays the window end
    pulse_reset();
    repeat (24) cyc(4'b0011, 4'b0000, 1'b0);
    repeat (7) cyc(4'b0000, 4'b0000, 1'b1);
    repeat (10) cyc(4'b0000, 4'b0000, 1'b0);
    repeat (20) cyc(4'b0000, 4'b0000, 1'b1);

    // Level 2, then asynchronous reset at wcnt=9
    pulse_reset();
    repeat (16) cyc(4'b0011, 4'b0000, 1'b0);
    cyc(4'b0000, 4'b1000, 1'b0);
    repeat (16) cyc(4'b0000, 4'b0000, 1'b1);
    repeat (9) cyc(4'b0000, 4'b0000, 1'b1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_out", congestion_out, 0);
    check("async_valid", congestion_valid, 0);
    check("async_err", err_flag, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) cyc(4'b0000, 4'b0000, 1'b1);

    // Randomised traffic: fill-biased then drain-biased
    pulse_reset();
    for (int i = 0; i < 800; i++) begin
      for (int p = 0; p < 4; p++) begin
        f[p] = ($urandom_range(0, 99) < ((i < 400) ? 55 : 25));
        c[p] = ($urandom_range(0, 99) < ((i < 400) ? 25 : 55));
      end
      cyc(f, c, ($urandom_range(0, 7) != 0));
    end

    repeat (3) cyc(4'b0000, 4'b0000, 1'b0);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
